// File: rtl/data_memory_sync.sv
// data_memory_sync
// Byte-addressed synchronous data memory for the MEM stage of the pipelined
// MIPS. It supports word and byte loads/stores, with sign or zero extension
// on byte loads. Loads return one cycle after the request and stores commit
// at the clock edge. Reset runs a clear sequence that zeroes every word while
// busy is high. Rejected requests raise a one-cycle fault pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, restarts the clear sequence
//   address      byte address, word index = address[ADDR_W-1:OFF]
//   write_data   store data; byte stores use write_data[7:0]
//   memWrite     store request
//   memRead      load request
//   mem_byte     1 = byte access, 0 = word access
//   load_signed  byte loads: 1 = sign-extend, 0 = zero-extend
//   read_data    registered load result
//   read_valid   one-cycle pulse, read_data holds a new load result
//   busy         clear sequence in progress, requests are ignored
//   fault        one-cycle pulse, the previous request was rejected
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zeroing word[cnt_q] each cycle, requests ignored, busy = 1
// S_READY | servicing load/store requests; left only through rst

module data_memory_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic              mem_byte,
  input  logic              load_signed,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              fault
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFF;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(DEPTH);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              fault_q, fault_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // request decode
  logic [IDX_W-1:0]  idx;
  logic [OFF-1:0]    lane;
  logic [AW-1:0]     widx;
  logic              req;
  logic              both_req;
  logic              misaligned;
  logic              out_of_range;
  logic              illegal;

  assign idx          = address[ADDR_W-1:OFF];
  assign lane         = address[OFF-1:0];
  assign widx         = idx[AW-1:0];
  assign req          = memRead | memWrite;
  assign both_req     = memRead & memWrite;
  assign misaligned   = ~mem_byte & (lane != '0);
  assign out_of_range = ({1'b0, idx} >= DEPTH_X);
  assign illegal      = both_req | misaligned | out_of_range;

  // read path: array read feeds the read_data register only
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [DATA_W-1:0] rd_byte_ext;

  assign rd_word = mem_q[widx];

  always_comb begin
    rd_byte = '0;
    for (int l = 0; l < NB; l++) begin
      if (lane == OFF'(l)) rd_byte = rd_word[l*8 +: 8];
    end
  end

  assign rd_byte_ext = {{(DATA_W-8){load_signed & rd_byte[7]}}, rd_byte};

  // single write port shared by the clear sequence and stores
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    fault_d      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = widx;
    mem_wdata    = write_data;
    mem_be       = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end

      S_READY: begin
        if (req) begin
          if (illegal) begin
            fault_d = 1'b1;
          end else if (memWrite) begin
            mem_we = 1'b1;
            if (mem_byte) begin
              // replicate the byte on every lane, the enable picks one
              mem_wdata = {NB{write_data[7:0]}};
              mem_be    = NB'(1) << lane;
            end else begin
              mem_be = '1;
            end
          end else begin
            read_valid_d = 1'b1;
            read_data_d  = mem_byte ? rd_byte_ext : rd_word;
          end
        end
      end

      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
    end
  end

  // no reset on the array itself; the clear sequence zeroes it
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int l = 0; l < NB; l++) begin
        if (mem_be[l]) mem_q[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign fault      = fault_q;
  assign busy       = (state_q == S_CLEAR);

endmodule

// File: tb/tb_data_memory_sync.sv
module tb_data_memory_sync;

  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_FLT  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;
  logic [15:0] last16 = '0;
  logic [31:0] last32 = '0;

  // 16-bit instance
  logic        rst16, mw16, mr16, mb16, ls16;
  logic [15:0] addr16, wd16, rd16;
  logic        rv16, busy16, f16;

  // 32-bit instance
  logic        rst32, mw32, mr32, mb32, ls32;
  logic [15:0] addr32;
  logic [31:0] wd32, rd32;
  logic        rv32, busy32, f32;

  data_memory_sync dut16 (
    .clk(clk), .rst(rst16), .address(addr16), .write_data(wd16),
    .memWrite(mw16), .memRead(mr16), .mem_byte(mb16), .load_signed(ls16),
    .read_data(rd16), .read_valid(rv16), .busy(busy16), .fault(f16)
  );

  data_memory_sync #(.DATA_W(32), .ADDR_W(16), .DEPTH(64)) dut32 (
    .clk(clk), .rst(rst32), .address(addr32), .write_data(wd32),
    .memWrite(mw32), .memRead(mr32), .mem_byte(mb32), .load_signed(ls32),
    .read_data(rd32), .read_valid(rv32), .busy(busy32), .fault(f32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every output pulse must match the head of its queue
  always @(negedge clk) begin
    if (rv16 === 1'b1 || f16 === 1'b1) begin
      tests++;
      if (rv16 && f16) begin
        fails++;
        $display("FAIL pulse16_both: read_valid=1 fault=1 cycle %0d", cyc);
      end else if (q16.size() == 0) begin
        fails++;
        $display("FAIL unexpected16: read_valid=%0b fault=%0b read_data=%h cycle %0d", rv16, f16, rd16, cyc);
      end else begin
        e16 = q16.pop_front();
        if ((e16.kind == K_RD) !== rv16 || e16.data[15:0] !== rd16 || e16.due != cyc) begin
          fails++;
          $display("FAIL resp16: got rv=%0b fault=%0b data=%h cycle %0d, expected kind=%0d data=%h cycle %0d",
                   rv16, f16, rd16, cyc, e16.kind, e16.data[15:0], e16.due);
        end
      end
    end
    if (rv32 === 1'b1 || f32 === 1'b1) begin
      tests++;
      if (rv32 && f32) begin
        fails++;
        $display("FAIL pulse32_both: read_valid=1 fault=1 cycle %0d", cyc);
      end else if (q32.size() == 0) begin
        fails++;
        $display("FAIL unexpected32: read_valid=%0b fault=%0b read_data=%h cycle %0d", rv32, f32, rd32, cyc);
      end else begin
        e32 = q32.pop_front();
        if ((e32.kind == K_RD) !== rv32 || e32.data !== rd32 || e32.due != cyc) begin
          fails++;
          $display("FAIL resp32: got rv=%0b fault=%0b data=%h cycle %0d, expected kind=%0d data=%h cycle %0d",
                   rv32, f32, rd32, cyc, e32.kind, e32.data, e32.due);
        end
      end
    end
  end

  // ---------------- 16-bit helpers ----------------
  task automatic issue16(input logic rd, input logic wr, input logic byt, input logic sgn,
                         input logic [15:0] a, input logic [15:0] d, input int kind,
                         input logic [15:0] e);
    @(posedge clk); #1;
    mr16 = rd; mw16 = wr; mb16 = byt; ls16 = sgn; addr16 = a; wd16 = d;
    if (kind == K_RD) begin
      q16.push_back('{kind: K_RD, data: {16'h0, e}, due: cyc + 1});
      last16 = e;
    end else if (kind == K_FLT) begin
      q16.push_back('{kind: K_FLT, data: {16'h0, last16}, due: cyc + 1});
    end
  endtask

  task automatic idle16();
    @(posedge clk); #1;
    mr16 = 0; mw16 = 0; mb16 = 0; ls16 = 0; addr16 = '0; wd16 = '0;
  endtask

  task automatic reset16();
    @(posedge clk); #1;
    mr16 = 0; mw16 = 0; rst16 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst16_read_data", {16'h0, rd16}, 32'h0);
    check("rst16_read_valid", {31'h0, rv16}, 32'h0);
    check("rst16_fault", {31'h0, f16}, 32'h0);
    check("rst16_busy", {31'h0, busy16}, 32'h1);
    rst16 = 0;
    last16 = '0;
  endtask

  task automatic wait_clear16(input int start, input int exp_n);
    int n;
    n = start;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy16 === 1'b1 && n < 2000);
    check("clear_len16", n, exp_n);
  endtask

  // ---------------- 32-bit helpers ----------------
  task automatic issue32(input logic rd, input logic wr, input logic byt, input logic sgn,
                         input logic [15:0] a, input logic [31:0] d, input int kind,
                         input logic [31:0] e);
    @(posedge clk); #1;
    mr32 = rd; mw32 = wr; mb32 = byt; ls32 = sgn; addr32 = a; wd32 = d;
    if (kind == K_RD) begin
      q32.push_back('{kind: K_RD, data: e, due: cyc + 1});
      last32 = e;
    end else if (kind == K_FLT) begin
      q32.push_back('{kind: K_FLT, data: last32, due: cyc + 1});
    end
  endtask

  task automatic idle32();
    @(posedge clk); #1;
    mr32 = 0; mw32 = 0; mb32 = 0; ls32 = 0; addr32 = '0; wd32 = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst16 = 1; mw16 = 0; mr16 = 0; mb16 = 0; ls16 = 0; addr16 = '0; wd16 = '0;
    rst32 = 1; mw32 = 0; mr32 = 0; mb32 = 0; ls32 = 0; addr32 = '0; wd32 = '0;

    // 1: clear length, post-clear reads, restart mid-clear
    reset16();
    wait_clear16(0, 256);
    issue16(1, 0, 0, 0, 16'h0000, 16'h0, K_RD, 16'h0000);
    issue16(1, 0, 0, 0, 16'h01FE, 16'h0, K_RD, 16'h0000);
    idle16();
    reset16();
    repeat (100) idle16();
    check("busy_mid_clear16", {31'h0, busy16}, 32'h1);
    reset16();
    wait_clear16(0, 256);

    // 2: store then load, back-to-back sweep
    issue16(0, 1, 0, 0, 16'h0004, 16'hBEEF, K_NONE, 16'h0);
    issue16(1, 0, 0, 0, 16'h0004, 16'h0, K_RD, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      issue16(1, 0, 0, 0, 16'(2 * i), 16'h0, K_RD, (i == 2) ? 16'hBEEF : 16'h0000);
    end
    idle16();

    // 3: byte store and byte loads
    issue16(0, 1, 1, 0, 16'h0005, 16'h0080, K_NONE, 16'h0);
    issue16(1, 0, 0, 0, 16'h0004, 16'h0, K_RD, 16'h80EF);
    issue16(1, 0, 1, 1, 16'h0005, 16'h0, K_RD, 16'hFF80);
    issue16(1, 0, 1, 0, 16'h0005, 16'h0, K_RD, 16'h0080);
    issue16(1, 0, 1, 1, 16'h0004, 16'h0, K_RD, 16'hFFEF);
    issue16(1, 0, 1, 0, 16'h0004, 16'h0, K_RD, 16'h00EF);
    issue16(1, 0, 1, 1, 16'h01FF, 16'h0, K_RD, 16'h0000);
    idle16();

    // 4: rejected requests keep memory and read_data intact
    issue16(1, 0, 0, 0, 16'h0003, 16'h0, K_FLT, 16'h0);
    issue16(0, 1, 0, 0, 16'h0200, 16'hAAAA, K_FLT, 16'h0);
    issue16(1, 1, 0, 0, 16'h0004, 16'h1234, K_FLT, 16'h0);
    issue16(1, 0, 1, 0, 16'h0200, 16'h0, K_FLT, 16'h0);
    idle16();
    issue16(1, 0, 0, 0, 16'h0004, 16'h0, K_RD, 16'h80EF);
    idle16();

    // 5: request coincident with rst is dropped; requests during clear ignored
    @(posedge clk); #1;
    mr16 = 1; addr16 = 16'h0004; rst16 = 1;
    @(posedge clk); #1;
    mr16 = 0;
    @(posedge clk); #1;
    check("rst16_drop_read_data", {16'h0, rd16}, 32'h0);
    rst16 = 0;
    last16 = '0;
    repeat (100) idle16();
    issue16(0, 1, 0, 0, 16'h0010, 16'h5555, K_NONE, 16'h0);
    issue16(1, 0, 0, 0, 16'h0004, 16'h0, K_NONE, 16'h0);
    issue16(1, 1, 0, 0, 16'h0003, 16'h0, K_NONE, 16'h0);
    idle16();
    wait_clear16(104, 256);
    issue16(1, 0, 0, 0, 16'h0010, 16'h0, K_RD, 16'h0000);
    issue16(1, 0, 0, 0, 16'h0004, 16'h0, K_RD, 16'h0000);
    idle16();

    // 6: 32-bit instance
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst32_read_data", rd32, 32'h0);
    check("rst32_busy", {31'h0, busy32}, 32'h1);
    rst32 = 0;
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (busy32 === 1'b1 && n < 2000);
      check("clear_len32", n, 64);
    end
    issue32(0, 1, 0, 0, 16'h0008, 32'hDEADBEEF, K_NONE, 32'h0);
    issue32(0, 1, 1, 0, 16'h000B, 32'h00000011, K_NONE, 32'h0);
    issue32(1, 0, 0, 0, 16'h0008, 32'h0, K_RD, 32'h11ADBEEF);
    issue32(1, 0, 0, 0, 16'h000A, 32'h0, K_FLT, 32'h0);
    issue32(0, 1, 0, 0, 16'h0100, 32'h12345678, K_FLT, 32'h0);
    issue32(1, 0, 0, 0, 16'h0100, 32'h0, K_FLT, 32'h0);
    issue32(1, 0, 1, 1, 16'h000B, 32'h0, K_RD, 32'h00000011);
    issue32(1, 0, 1, 1, 16'h0009, 32'h0, K_RD, 32'hFFFFFFBE);
    issue32(1, 0, 1, 0, 16'h0009, 32'h0, K_RD, 32'h000000BE);
    issue32(1, 0, 0, 0, 16'h00FC, 32'h0, K_RD, 32'h00000000);
    issue32(1, 0, 0, 0, 16'h0008, 32'h0, K_RD, 32'h11ADBEEF);
    idle32();

    repeat (4) idle16();
    check("pending16", q16.size(), 0);
    check("pending32", q32.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
